// File: rtl/compute_dispatch_if.sv
// Command, host-memory, compute-unit and status signals of compute_dispatch.
// slave is the dispatcher's view; master is the host/unit-side view.
interface compute_dispatch_if #(
  parameter int unsigned DW    = 64,
  parameter int unsigned AW    = 10,
  parameter int unsigned NUNIT = 4
);
  logic [3*AW+4:0]     cmd_in;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [AW-1:0]       ext_addr;
  logic [DW-1:0]       ext_din;
  logic                ext_we;
  logic [NUNIT-1:0]    unit_start;
  logic [NUNIT-1:0]    unit_done;
  logic [NUNIT*AW-1:0] unit_rd_addr;
  logic [NUNIT*AW-1:0] unit_wt_addr;
  logic [NUNIT-1:0]    unit_we;
  logic [NUNIT*DW-1:0] unit_wdata;
  logic [NUNIT-1:0]    unit_op2_sel;
  logic [3*AW-1:0]     cur_op;
  logic [AW-1:0]       mem_addra;
  logic                mem_wea;
  logic [DW-1:0]       mem_dina;
  logic [AW-1:0]       mem_addrb;
  logic                busy;
  logic                done;
  logic                err_illegal;
  logic                err_timeout;

  modport slave (
    input  cmd_in, cmd_valid, ext_addr, ext_din, ext_we,
           unit_done, unit_rd_addr, unit_wt_addr, unit_we, unit_wdata, unit_op2_sel,
    output cmd_ready, unit_start, cur_op, mem_addra, mem_wea, mem_dina, mem_addrb,
           busy, done, err_illegal, err_timeout
  );

  modport master (
    output cmd_in, cmd_valid, ext_addr, ext_din, ext_we,
           unit_done, unit_rd_addr, unit_wt_addr, unit_we, unit_wdata, unit_op2_sel,
    input  cmd_ready, unit_start, cur_op, mem_addra, mem_wea, mem_dina, mem_addrb,
           busy, done, err_illegal, err_timeout
  );
endinterface

// File: rtl/compute_dispatch.sv
// Command FIFO plus IDLE/ISSUE/RUN/DONE sequencer that starts one compute unit at a
// time and muxes the shared memory port between the host and the active unit.
module compute_dispatch #(
  parameter int unsigned DW       = 64,
  parameter int unsigned AW       = 10,
  parameter int unsigned NUNIT    = 4,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned OPC_BASE = 18,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic               clk,
  input  logic               rst,
  compute_dispatch_if.slave  bus
);

  localparam int unsigned CW = 3*AW + 5;
  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned NW = PW + 1;
  localparam int unsigned UW = (NUNIT > 1) ? $clog2(NUNIT) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     fifo_q [QDEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]     count_q, count_d;
  logic              push, pop, full, empty;

  logic [3*AW-1:0]   cur_op_q, cur_op_d;
  logic [UW-1:0]     sel_q, sel_d;
  logic              is_unit_q, is_unit_d, is_nop_q, is_nop_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [NUNIT-1:0]  unit_start_q, unit_start_d;
  logic              done_q, done_d, busy_q, busy_d;
  logic              err_illegal_q, err_illegal_d, err_timeout_q, err_timeout_d;

  logic [CW-1:0]     head;
  logic [31:0]       head_ins32;
  logic              head_is_unit, head_is_nop;
  logic [UW-1:0]     head_sel;

  logic              u_done, u_we, u_op2_sel;
  logic [AW-1:0]     u_rd, u_wt, mem_addra, mem_addrb, rd_base;
  logic [DW-1:0]     u_wdata, mem_dina;
  logic              mem_wea;

  // Full is taken from the pre-pop count so a pop never re-opens a full FIFO that cycle.
  assign full    = (count_q == NW'(QDEPTH));
  assign empty   = (count_q == '0);
  assign push    = bus.cmd_valid && !full;
  assign pop     = (state_q == IDLE) && !empty;
  assign count_d = count_q + NW'(push) - NW'(pop);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.cmd_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  assign head         = fifo_q[rd_ptr_q];
  assign head_ins32   = 32'(head[4:0]);
  assign head_is_unit = (head_ins32 >= OPC_BASE) && (head_ins32 < OPC_BASE + NUNIT);
  assign head_is_nop  = (head[4:0] == 5'd0);
  assign head_sel     = UW'(head_ins32 - OPC_BASE);

  // Pick the selected unit's request signals.
  always_comb begin
    u_done    = 1'b0;
    u_we      = 1'b0;
    u_op2_sel = 1'b0;
    u_rd      = '0;
    u_wt      = '0;
    u_wdata   = '0;
    for (int k = 0; k < NUNIT; k++) begin
      if (sel_q == UW'(k)) begin
        u_done    = bus.unit_done[k];
        u_we      = bus.unit_we[k];
        u_op2_sel = bus.unit_op2_sel[k];
        u_rd      = bus.unit_rd_addr[k*AW +: AW];
        u_wt      = bus.unit_wt_addr[k*AW +: AW];
        u_wdata   = bus.unit_wdata[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_op_q      <= '0;
      sel_q         <= '0;
      is_unit_q     <= 1'b0;
      is_nop_q      <= 1'b0;
      cnt_q         <= '0;
      unit_start_q  <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_op_q      <= cur_op_d;
      sel_q         <= sel_d;
      is_unit_q     <= is_unit_d;
      is_nop_q      <= is_nop_d;
      cnt_q         <= cnt_d;
      unit_start_q  <= unit_start_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Start and done pulses are decided one cycle early so they register into ISSUE/DONE.
  always_comb begin
    state_d       = state_q;
    cur_op_d      = cur_op_q;
    sel_d         = sel_q;
    is_unit_d     = is_unit_q;
    is_nop_d      = is_nop_q;
    cnt_d         = cnt_q;
    unit_start_d  = '0;
    done_d        = 1'b0;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d   = ISSUE;
          cur_op_d  = head[CW-1:5];
          sel_d     = head_sel;
          is_unit_d = head_is_unit;
          is_nop_d  = head_is_nop;
          if (head_is_unit) unit_start_d[head_sel] = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (is_unit_q) begin
          state_d = RUN;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          if (!is_nop_q) err_illegal_d = 1'b1;
        end
      end
      RUN: begin
        if (u_done) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (cnt_q == TW'(TIMEOUT)) begin
          state_d       = DONE;
          done_d        = 1'b1;
          err_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  // Host owns the memory port in IDLE; the active unit owns it otherwise.
  always_comb begin
    rd_base   = u_op2_sel ? cur_op_q[2*AW-1 -: AW] : cur_op_q[AW-1:0];
    mem_addra = bus.ext_addr;
    mem_addrb = bus.ext_addr;
    mem_wea   = bus.ext_we;
    mem_dina  = bus.ext_din;
    if (state_q != IDLE) begin
      mem_addra = cur_op_q[3*AW-1 -: AW] + u_wt;
      mem_addrb = rd_base + u_rd;
      mem_wea   = (state_q == RUN) && u_we;
      mem_dina  = u_wdata;
    end
  end

  assign bus.cmd_ready   = !full;
  assign bus.unit_start  = unit_start_q;
  assign bus.cur_op      = cur_op_q;
  assign bus.mem_addra   = mem_addra;
  assign bus.mem_addrb   = mem_addrb;
  assign bus.mem_wea     = mem_wea;
  assign bus.mem_dina    = mem_dina;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_compute_dispatch.sv
// Directed bench for compute_dispatch with TIMEOUT shortened to 8.
module tb_compute_dispatch;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 10;
  localparam int unsigned NUNIT = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks, errors;

  always #5 clk = ~clk;

  compute_dispatch_if #(.DW(DW), .AW(AW), .NUNIT(NUNIT)) bus ();

  compute_dispatch #(
    .DW(DW), .AW(AW), .NUNIT(NUNIT), .QDEPTH(4), .OPC_BASE(18), .TIMEOUT(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3*AW+4:0] mk(input logic [4:0] ins, input logic [AW-1:0] o1,
                                         input logic [AW-1:0] o2, input logic [AW-1:0] o3);
    return {o3, o2, o1, ins};
  endfunction

  task automatic set_unit(input int k, input logic [AW-1:0] rd, input logic [AW-1:0] wt,
                          input logic we, input logic [DW-1:0] wd, input logic sel);
    bus.unit_rd_addr[k*AW +: AW] = rd;
    bus.unit_wt_addr[k*AW +: AW] = wt;
    bus.unit_we[k]               = we;
    bus.unit_wdata[k*DW +: DW]   = wd;
    bus.unit_op2_sel[k]          = sel;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  logic [5:0] e_done, e_wea, e_err, e_busy;
  int         n_done;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.cmd_in = '0;  bus.cmd_valid = 1'b0;
    bus.ext_addr = '0; bus.ext_din = '0; bus.ext_we = 1'b0;
    bus.unit_done = '0; bus.unit_rd_addr = '0; bus.unit_wt_addr = '0;
    bus.unit_we = '0; bus.unit_wdata = '0; bus.unit_op2_sel = '0;
    step();
    chk("rst_start", bus.unit_start, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_errs", {bus.err_illegal, bus.err_timeout}, 0);
    chk("rst_curop", bus.cur_op, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    step();
    rst = 1'b0;
    step();

    // Single unit-0 command: latency of start, done and busy.
    set_unit(0, 10'h004, 10'h005, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0);
    bus.cmd_in = mk(5'd18, 10'h010, 10'h000, 10'h100);
    bus.cmd_valid = 1'b1;
    chk("a_ready", bus.cmd_ready, 1);
    step();
    bus.cmd_valid = 1'b0;
    chk("a_busy_t1", bus.busy, 1);
    chk("a_start_t1", bus.unit_start, 0);
    step();
    chk("a_start_t2", bus.unit_start, 4'b0001);
    chk("a_curop", bus.cur_op, {10'h100, 10'h000, 10'h010});
    chk("a_wea_issue", bus.mem_wea, 0);
    step();
    chk("a_start_t3", bus.unit_start, 0);
    chk("a_addra", bus.mem_addra, 10'h105);
    chk("a_addrb", bus.mem_addrb, 10'h014);
    chk("a_wea_run", bus.mem_wea, 1);
    chk("a_dina", bus.mem_dina, 64'hDEAD_BEEF_0000_0001);
    step();
    step();
    bus.unit_done = 4'b0001;
    step();
    bus.unit_done = '0;
    chk("a_done_t6", bus.done, 1);
    chk("a_busy_t6", bus.busy, 1);
    chk("a_wea_done", bus.mem_wea, 0);
    step();
    chk("a_done_t7", bus.done, 0);
    chk("a_busy_t7", bus.busy, 0);
    chk("a_curop_hold", bus.cur_op, {10'h100, 10'h000, 10'h010});
    bus.ext_addr = 10'h2AA; bus.ext_we = 1'b1; bus.ext_din = 64'h1234;
    #1;
    chk("a_idle_addra", bus.mem_addra, 10'h2AA);
    chk("a_idle_addrb", bus.mem_addrb, 10'h2AA);
    chk("a_idle_wea", bus.mem_wea, 1);
    chk("a_idle_dina", bus.mem_dina, 64'h1234);
    bus.ext_we = 1'b0;

    // Unit 1 with OP2 base and address wrap; unit 0 is a decoy.
    set_unit(0, 10'h111, 10'h222, 1'b1, 64'h0BAD, 1'b0);
    set_unit(1, 10'h020, 10'h002, 1'b1, 64'hCAFE, 1'b1);
    bus.cmd_in = mk(5'd19, 10'h055, 10'h3F0, 10'h3FF);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk("b_start", bus.unit_start, 4'b0010);
    step();
    chk("b_addrb_wrap", bus.mem_addrb, 10'h010);
    chk("b_addra_wrap", bus.mem_addra, 10'h001);
    chk("b_dina", bus.mem_dina, 64'hCAFE);
    bus.unit_done = 4'b0001;
    step();
    bus.unit_done = '0;
    chk("b_ignore_done", bus.done, 0);
    bus.unit_op2_sel[1] = 1'b0;
    #1;
    chk("b_addrb_op1", bus.mem_addrb, 10'h075);
    bus.unit_done = 4'b0010;
    step();
    bus.unit_done = '0;
    chk("b_done", bus.done, 1);
    step();
    chk("b_idle", bus.busy, 0);

    // Illegal opcode then NOP, with ext_we held high throughout.
    bus.ext_we = 1'b1;
    bus.cmd_in = mk(5'd31, 10'h001, 10'h002, 10'h003);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_in = mk(5'd0, 10'h004, 10'h005, 10'h006);
    step();
    bus.cmd_valid = 1'b0;
    e_done = 6'b010010;
    e_wea  = 6'b001001;
    e_err  = 6'b011111;
    e_busy = 6'b111110;
    for (int i = 0; i < 6; i++) begin
      chk("c_done", bus.done, e_done[5-i]);
      chk("c_wea", bus.mem_wea, e_wea[5-i]);
      chk("c_err_illegal", bus.err_illegal, e_err[5-i]);
      chk("c_busy", bus.busy, e_busy[5-i]);
      chk("c_no_start", bus.unit_start, 0);
      if (i < 5) step();
    end
    bus.ext_we = 1'b0;

    // Asynchronous reset mid-RUN with two commands queued.
    bus.cmd_in = mk(5'd18, 10'h000, 10'h000, 10'h000);
    bus.cmd_valid = 1'b1;
    step();
    step();
    step();
    bus.cmd_valid = 1'b0;
    chk("d_busy_pre", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("d_start", bus.unit_start, 0);
    chk("d_done", bus.done, 0);
    chk("d_busy", bus.busy, 0);
    chk("d_errs", {bus.err_illegal, bus.err_timeout}, 0);
    chk("d_curop", bus.cur_op, 0);
    chk("d_ready", bus.cmd_ready, 1);
    step();
    step();
    rst = 1'b0;
    bus.unit_done = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("d_quiet", {bus.unit_start, bus.done, bus.busy}, 0);
    end
    bus.unit_done = '0;

    // Timeout after 9 RUN cycles, then a completion on the last count.
    set_unit(0, 10'h000, 10'h000, 1'b0, 64'h0, 1'b0);
    bus.cmd_in = mk(5'd18, 10'h000, 10'h000, 10'h000);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 8; i++) step();
    chk("e_pre_done", bus.done, 0);
    chk("e_pre_tmo", bus.err_timeout, 0);
    step();
    chk("e_tmo_done", bus.done, 1);
    chk("e_tmo_flag", bus.err_timeout, 1);
    step();
    chk("e_tmo_idle", bus.busy, 0);
    chk("e_tmo_sticky", bus.err_timeout, 1);
    do_reset();
    chk("e_tmo_clr", bus.err_timeout, 0);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 8; i++) step();
    bus.unit_done = 4'b0001;
    step();
    bus.unit_done = '0;
    chk("e_win_done", bus.done, 1);
    chk("e_win_tmo", bus.err_timeout, 0);
    step();
    chk("e_win_idle", bus.busy, 0);

    // FIFO fill while a unit runs; fifth command waits for a pop.
    bus.cmd_in = mk(5'd18, 10'h000, 10'h000, 10'h000);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    bus.cmd_in = mk(5'd0, 10'h000, 10'h000, 10'h000);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("f_ready_open", bus.cmd_ready, 1);
      step();
    end
    chk("f_full", bus.cmd_ready, 0);
    bus.unit_done = 4'b0001;
    step();
    bus.unit_done = '0;
    chk("f_full_done", bus.cmd_ready, 0);
    step();
    chk("f_full_pop", bus.cmd_ready, 0);
    step();
    chk("f_reopen", bus.cmd_ready, 1);
    step();
    bus.cmd_valid = 1'b0;
    chk("f_refull", bus.cmd_ready, 0);
    n_done = 0;
    for (int i = 0; i < 60 && bus.busy; i++) begin
      if (bus.done) n_done++;
      step();
    end
    chk("f_drain", bus.busy, 0);
    chk("f_nops_done", 64'(n_done), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
